// File: rtl/tpg_pkg.sv
// tpg_pkg: shared shadow-register addresses and run-state encoding for the TPG timing controller
package tpg_pkg;
    localparam int NUM_TIMING_REGS = 10;
    localparam logic [3:0] ADDR_HS_START   = 4'd0;
    localparam logic [3:0] ADDR_HS_END     = 4'd1;
    localparam logic [3:0] ADDR_HACT_START = 4'd2;
    localparam logic [3:0] ADDR_HACT_END   = 4'd3;
    localparam logic [3:0] ADDR_H_END      = 4'd4;
    localparam logic [3:0] ADDR_VS_START   = 4'd5;
    localparam logic [3:0] ADDR_VS_END     = 4'd6;
    localparam logic [3:0] ADDR_VACT_START = 4'd7;
    localparam logic [3:0] ADDR_VACT_END   = 4'd8;
    localparam logic [3:0] ADDR_V_END      = 4'd9;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} tpgState;
endpackage

// File: rtl/tpg_timing_check.sv
// tpg_timing_check: combinational validator, ok=1 when every sync/active window is ordered and fits the line/frame
// Ports: ten timing values in (H_BITS horizontal, V_BITS vertical), ok out.
module tpg_timing_check #(
    parameter int H_BITS = 12,
    parameter int V_BITS = 12
) (
    input  logic [H_BITS-1:0] hsStart,
    input  logic [H_BITS-1:0] hsEnd,
    input  logic [H_BITS-1:0] hactStart,
    input  logic [H_BITS-1:0] hactEnd,
    input  logic [H_BITS-1:0] hEnd,
    input  logic [V_BITS-1:0] vsStart,
    input  logic [V_BITS-1:0] vsEnd,
    input  logic [V_BITS-1:0] vactStart,
    input  logic [V_BITS-1:0] vactEnd,
    input  logic [V_BITS-1:0] vEnd,
    output logic              ok
);
    assign ok = hsStart < hsEnd && hsEnd <= hEnd && hactStart < hactEnd && hactEnd <= hEnd &&
                vsStart < vsEnd && vsEnd <= vEnd && vactStart < vactEnd && vactEnd <= vEnd;
endmodule

// File: rtl/tpg_timing_ctrl.sv
// tpg_timing_ctrl: shadow/active timing banks with frame-synchronous validated commit, generator run control and frame count
// Ports: cfg_* shadow write/commit, start/stop run pulses, vs_q generator vsync; t* active timing bank,
// tpg_rst_n generator reset, busy/commit_pending/act_valid status, cfg_err/drain_tmo sticky flags, frame_cnt.
module tpg_timing_ctrl
    import tpg_pkg::*;
#(
    parameter  int H_BITS    = 12,
    parameter  int V_BITS    = 12,
    parameter  int FC_BITS   = 16,
    parameter  int DRAIN_MAX = 2**22,
    localparam int W         = (H_BITS > V_BITS) ? H_BITS : V_BITS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_wr,
    input  logic [3:0]         cfg_addr,
    input  logic [W-1:0]       cfg_wdata,
    input  logic               cfg_commit,
    input  logic               start,
    input  logic               stop,
    input  logic               vs_q,
    output logic [H_BITS-1:0]  tHS_START,
    output logic [H_BITS-1:0]  tHS_END,
    output logic [H_BITS-1:0]  tHACT_START,
    output logic [H_BITS-1:0]  tHACT_END,
    output logic [H_BITS-1:0]  tH_END,
    output logic [V_BITS-1:0]  tVS_START,
    output logic [V_BITS-1:0]  tVS_END,
    output logic [V_BITS-1:0]  tVACT_START,
    output logic [V_BITS-1:0]  tVACT_END,
    output logic [V_BITS-1:0]  tV_END,
    output logic               tpg_rst_n,
    output logic               busy,
    output logic               commit_pending,
    output logic               act_valid,
    output logic               cfg_err,
    output logic               drain_tmo,
    output logic [FC_BITS-1:0] frame_cnt
);
    localparam int DC_BITS = $clog2(DRAIN_MAX);
    tpgState state, stateNext;
    logic [W-1:0] shadow [NUM_TIMING_REGS];
    logic [W-1:0] active [NUM_TIMING_REGS];
    logic [DC_BITS-1:0] drainCnt;
    logic vsD, vsRise, wrBad, apply, ok, startReq, startOk, startBad, tmo;
    assign vsRise   = vs_q & ~vsD;
    assign wrBad    = cfg_wr && cfg_addr >= 4'(NUM_TIMING_REGS);
    // in IDLE any cycle is a safe commit point; while running only the frame boundary is
    assign apply    = commit_pending && (state == IDLE || vsRise);
    assign startReq = state == IDLE && start && !stop;
    assign startOk  = startReq && act_valid;
    assign startBad = startReq && !act_valid;
    // a clean vsync end of drain takes precedence over a coincident timeout
    assign tmo      = state == DRAIN && !vsRise && drainCnt == DC_BITS'(DRAIN_MAX - 1);
    tpg_timing_check #(.H_BITS(H_BITS), .V_BITS(V_BITS)) check (
        .hsStart  (shadow[ADDR_HS_START][H_BITS-1:0]),
        .hsEnd    (shadow[ADDR_HS_END][H_BITS-1:0]),
        .hactStart(shadow[ADDR_HACT_START][H_BITS-1:0]),
        .hactEnd  (shadow[ADDR_HACT_END][H_BITS-1:0]),
        .hEnd     (shadow[ADDR_H_END][H_BITS-1:0]),
        .vsStart  (shadow[ADDR_VS_START][V_BITS-1:0]),
        .vsEnd    (shadow[ADDR_VS_END][V_BITS-1:0]),
        .vactStart(shadow[ADDR_VACT_START][V_BITS-1:0]),
        .vactEnd  (shadow[ADDR_VACT_END][V_BITS-1:0]),
        .vEnd     (shadow[ADDR_V_END][V_BITS-1:0]),
        .ok       (ok)
    );
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= stateNext;
    always_comb
        stateNext = startOk                                   ? RUN   :
                    (state == RUN && stop)                    ? DRAIN :
                    (state == DRAIN && (vsRise || tmo))       ? IDLE  : state;
    always_comb
        busy = state != IDLE;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow         <= '{default: '0};
            active         <= '{default: '0};
            act_valid      <= 1'b0;
            commit_pending <= 1'b0;
            cfg_err        <= 1'b0;
            drain_tmo      <= 1'b0;
            frame_cnt      <= '0;
            drainCnt       <= '0;
            tpg_rst_n      <= 1'b0;
            vsD            <= 1'b0;
        end else begin
            vsD <= vs_q;
            if (cfg_wr && !wrBad) shadow[cfg_addr] <= cfg_wdata;
            if (apply && ok) begin
                active    <= shadow;
                act_valid <= 1'b1;
            end
            // a commit arriving on the apply edge stays queued for the next commit point
            commit_pending <= cfg_commit || (commit_pending && !apply);
            cfg_err        <= (wrBad || (apply && !ok) || startBad) ? 1'b1 : startOk ? 1'b0 : cfg_err;
            drain_tmo      <= tmo ? 1'b1 : startOk ? 1'b0 : drain_tmo;
            frame_cnt      <= startOk ? '0 : (state != IDLE && vsRise) ? frame_cnt + 1'b1 : frame_cnt;
            drainCnt       <= state == DRAIN ? drainCnt + 1'b1 : '0;
            // registered so the generator leaves reset one cycle after RUN is entered
            tpg_rst_n      <= state != IDLE;
        end
    end
    assign tHS_START   = active[ADDR_HS_START][H_BITS-1:0];
    assign tHS_END     = active[ADDR_HS_END][H_BITS-1:0];
    assign tHACT_START = active[ADDR_HACT_START][H_BITS-1:0];
    assign tHACT_END   = active[ADDR_HACT_END][H_BITS-1:0];
    assign tH_END      = active[ADDR_H_END][H_BITS-1:0];
    assign tVS_START   = active[ADDR_VS_START][V_BITS-1:0];
    assign tVS_END     = active[ADDR_VS_END][V_BITS-1:0];
    assign tVACT_START = active[ADDR_VACT_START][V_BITS-1:0];
    assign tVACT_END   = active[ADDR_VACT_END][V_BITS-1:0];
    assign tV_END      = active[ADDR_V_END][V_BITS-1:0];
endmodule

// File: tb/tb_tpg_timing_ctrl.sv
// tb_tpg_timing_ctrl: directed and randomized check of tpg_timing_ctrl against a behavioural model
module tb_tpg_timing_ctrl;
    localparam int DM = 64;
    logic clk = 1'b0, rst = 1'b1, cfg_wr = 1'b0, cfg_commit = 1'b0, start = 1'b0, stop = 1'b0, vs_q = 1'b0;
    logic [3:0] cfg_addr = '0;
    logic [11:0] cfg_wdata = '0;
    logic [11:0] tHS_START, tHS_END, tHACT_START, tHACT_END, tH_END;
    logic [11:0] tVS_START, tVS_END, tVACT_START, tVACT_END, tV_END;
    logic tpg_rst_n, busy, commit_pending, act_valid, cfg_err, drain_tmo;
    logic [15:0] frame_cnt;
    tpg_timing_ctrl #(.H_BITS(12), .V_BITS(12), .FC_BITS(16), .DRAIN_MAX(DM)) dut (
        .clk(clk), .rst(rst), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .cfg_commit(cfg_commit), .start(start), .stop(stop), .vs_q(vs_q),
        .tHS_START(tHS_START), .tHS_END(tHS_END), .tHACT_START(tHACT_START), .tHACT_END(tHACT_END),
        .tH_END(tH_END), .tVS_START(tVS_START), .tVS_END(tVS_END), .tVACT_START(tVACT_START),
        .tVACT_END(tVACT_END), .tV_END(tV_END), .tpg_rst_n(tpg_rst_n), .busy(busy),
        .commit_pending(commit_pending), .act_valid(act_valid), .cfg_err(cfg_err),
        .drain_tmo(drain_tmo), .frame_cnt(frame_cnt)
    );
    always #5 clk = ~clk;
    int checks = 0, failures = 0;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask
    int mSh[10], mAct[10];
    int mFrames, mDrainCyc;
    bit mValid, mPend, mErr, mTmo, mRun, mDrain, mRstN, mPrevVs;
    int base[10] = '{16, 112, 160, 800, 800, 10, 12, 45, 525, 525};
    function automatic bit legal(input int s[10]);
        return s[0] < s[1] && s[1] <= s[4] && s[2] < s[3] && s[3] <= s[4] &&
               s[5] < s[6] && s[6] <= s[9] && s[7] < s[8] && s[8] <= s[9];
    endfunction
    task automatic mReset();
        mSh = '{default: 0};
        mAct = '{default: 0};
        {mValid, mPend, mErr, mTmo, mRun, mDrain, mRstN, mPrevVs} = '0;
        mFrames = 0;
        mDrainCyc = 0;
    endtask
    task automatic compareAll();
        logic [11:0] act[10];
        act = '{tHS_START, tHS_END, tHACT_START, tHACT_END, tH_END,
                tVS_START, tVS_END, tVACT_START, tVACT_END, tV_END};
        for (int i = 0; i < 10; i++) chk($sformatf("active%0d", i), 32'(act[i]), 32'(mAct[i]));
        chk("act_valid", 32'(act_valid), 32'(mValid));
        chk("commit_pending", 32'(commit_pending), 32'(mPend));
        chk("cfg_err", 32'(cfg_err), 32'(mErr));
        chk("drain_tmo", 32'(drain_tmo), 32'(mTmo));
        chk("busy", 32'(busy), 32'(mRun || mDrain));
        chk("tpg_rst_n", 32'(tpg_rst_n), 32'(mRstN));
        chk("frame_cnt", 32'(frame_cnt), 32'(mFrames));
    endtask
    task automatic step();
        bit rise, idle, apply, ok, acc, rej, bad, tmo;
        rise  = vs_q && !mPrevVs;
        idle  = !mRun && !mDrain;
        apply = mPend && (idle || rise);
        ok    = legal(mSh);
        acc   = idle && start && !stop && mValid;
        rej   = idle && start && !stop && !mValid;
        bad   = cfg_wr && cfg_addr > 9;
        tmo   = mDrain && !rise && mDrainCyc == DM - 1;
        mRstN = !idle;
        if (apply && ok) begin
            mAct = mSh;
            mValid = 1;
        end
        if (cfg_wr && !bad) mSh[cfg_addr] = int'(cfg_wdata);
        mPend = cfg_commit || (mPend && !apply);
        if (acc) begin
            mErr = 0;
            mTmo = 0;
            mFrames = 0;
        end
        if (bad || (apply && !ok) || rej) mErr = 1;
        if (tmo) mTmo = 1;
        if (!idle && rise) mFrames = (mFrames + 1) % 65536;
        mDrainCyc = mDrain ? mDrainCyc + 1 : 0;
        if (acc) mRun = 1;
        else if (mRun && stop) begin
            mRun = 0;
            mDrain = 1;
        end else if (mDrain && (rise || tmo)) mDrain = 0;
        mPrevVs = vs_q;
        @(posedge clk);
        #1;
        compareAll();
    endtask
    task automatic wr(input int a, input int d, input bit commit);
        cfg_wr = 1;
        cfg_addr = 4'(a);
        cfg_wdata = 12'(d);
        cfg_commit = commit;
        step();
        cfg_wr = 0;
        cfg_commit = 0;
    endtask
    task automatic pulse(input bit s, input bit p);
        start = s;
        stop = p;
        step();
        start = 0;
        stop = 0;
    endtask
    task automatic vsPulse();
        vs_q = 1;
        step();
        vs_q = 0;
        step();
    endtask
    initial begin
        int n;
        mReset();
        #12;
        chk("rst_tpg_rst_n", 32'(tpg_rst_n), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_act_valid", 32'(act_valid), 0);
        chk("rst_frame_cnt", 32'(frame_cnt), 0);
        chk("rst_cfg_err", 32'(cfg_err), 0);
        rst = 0;
        @(posedge clk);
        #1;
        pulse(1, 0);
        chk("rej_busy", 32'(busy), 0);
        chk("rej_cfg_err", 32'(cfg_err), 1);
        for (int i = 0; i < 10; i++) wr(i, base[i], i == 9);
        chk("commit_wait_valid", 32'(act_valid), 0);
        step();
        chk("commit_hact_end", 32'(tHACT_END), 800);
        chk("commit_v_end", 32'(tV_END), 525);
        chk("commit_valid", 32'(act_valid), 1);
        pulse(1, 0);
        chk("start_busy", 32'(busy), 1);
        chk("start_cfg_err", 32'(cfg_err), 0);
        chk("start_rst_n_lag", 32'(tpg_rst_n), 0);
        step();
        chk("start_rst_n", 32'(tpg_rst_n), 1);
        wr(3, 700, 1);
        step();
        step();
        chk("run_hact_hold", 32'(tHACT_END), 800);
        chk("run_pending", 32'(commit_pending), 1);
        vsPulse();
        chk("run_hact_new", 32'(tHACT_END), 700);
        chk("run_pending_clr", 32'(commit_pending), 0);
        wr(0, 200, 0);
        wr(1, 100, 1);
        vsPulse();
        chk("bad_hs_start", 32'(tHS_START), 16);
        chk("bad_cfg_err", 32'(cfg_err), 1);
        chk("bad_pending", 32'(commit_pending), 0);
        wr(0, 16, 0);
        wr(1, 112, 0);
        vsPulse();
        pulse(0, 1);
        step();
        step();
        chk("drain_busy", 32'(busy), 1);
        vsPulse();
        chk("drain_idle", 32'(busy), 0);
        chk("drain_frames", 32'(frame_cnt), 4);
        chk("drain_rst_n", 32'(tpg_rst_n), 0);
        pulse(1, 0);
        pulse(0, 1);
        n = 0;
        for (int k = 0; k < 200 && busy; k++) begin
            step();
            n++;
        end
        chk("tmo_cycles", 32'(n), DM);
        chk("tmo_flag", 32'(drain_tmo), 1);
        pulse(1, 1);
        chk("startstop_busy", 32'(busy), 0);
        chk("startstop_tmo", 32'(drain_tmo), 1);
        pulse(1, 0);
        step();
        step();
        #2;
        rst = 1;
        #1;
        chk("async_rst_n", 32'(tpg_rst_n), 0);
        chk("async_busy", 32'(busy), 0);
        mReset();
        vs_q = 0;
        @(posedge clk);
        #1;
        rst = 0;
        for (int i = 0; i < 10; i++) wr(i, base[i], i == 9);
        step();
        for (int c = 0; c < 1500; c++) begin
            cfg_wr = $urandom_range(0, 5) == 0;
            cfg_addr = 4'($urandom_range(0, 11));
            cfg_wdata = 12'((cfg_addr < 10 ? base[cfg_addr] : 0) + int'($urandom_range(0, 6)));
            cfg_commit = $urandom_range(0, 11) == 0;
            start = $urandom_range(0, 14) == 0;
            stop = $urandom_range(0, 24) == 0;
            if ($urandom_range(0, 7) == 0) vs_q = ~vs_q;
            step();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/tpg_timing_ctrl.md
Name: tpg_timing_ctrl

Overview:
Run-control and timing-configuration controller for the video test pattern generator. It holds a shadow bank of the ten raster timing values (HS/HACT/H_END, VS/VACT/V_END) and validates them before committing to an active bank that drives the generator's timing inputs. Commits are frame-synchronous, so a running raster never tears. It also owns the generator's active-low reset (start/stop with drain to end-of-frame) and counts frames.

Parameters:
H_BITS, 12, width of horizontal timing values
V_BITS, 12, width of vertical timing values
FC_BITS, 16, frame counter width
DRAIN_MAX, 2**22, cycles allowed in DRAIN before a forced stop

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
cfg_wr  in  1  shadow register write strobe
cfg_addr  in  4  shadow index: 0 HS_START, 1 HS_END, 2 HACT_START, 3 HACT_END, 4 H_END, 5 VS_START, 6 VS_END, 7 VACT_START, 8 VACT_END, 9 V_END
cfg_wdata  in  max(H_BITS,V_BITS)  write data, LSBs used per field width
cfg_commit  in  1  request shadow->active transfer
start  in  1  run request pulse
stop  in  1  stop request pulse
vs_q  in  1  vsync from generator
tHS_START..tV_END  out  H_BITS/V_BITS  active timing bank, 10 buses, widths as the generator ports
tpg_rst_n  out  1  generator reset, low = held in reset
busy  out  1  state != IDLE
commit_pending  out  1  commit requested, not yet applied
act_valid  out  1  active bank holds a validated config
cfg_err  out  1  sticky error
drain_tmo  out  1  sticky, last stop was forced by timeout
frame_cnt  out  FC_BITS  frames started since last start

Behaviour:
- Reset: all shadow/active regs 0, act_valid 0, state IDLE, tpg_rst_n 0, busy 0, commit_pending 0, cfg_err 0, drain_tmo 0, frame_cnt 0, vs_d 0.
- vs_rise = vs_q & ~vs_d; vs_d registered every cycle.
- Writes: cfg_wr with addr 0..9 updates shadow next edge. addr 10..15: no write, cfg_err set.
- cfg_commit sets commit_pending. Commit applies when pending and (state IDLE, or vs_rise in RUN/DRAIN). A write and a commit in the same cycle: the commit includes that write.
- Validation at apply: HS_START<HS_END<=H_END, HACT_START<HACT_END<=H_END, VS_START<VS_END<=V_END, VACT_START<VACT_END<=V_END. Pass: active <= shadow, act_valid 1. Fail: active unchanged, cfg_err 1. In both cases commit_pending clears on the same edge.
- FSM IDLE: tpg_rst_n 0.
  - start && !stop && act_valid -> RUN, frame_cnt 0, cfg_err 0, drain_tmo 0.
  - start while !act_valid: stay IDLE, cfg_err 1.
  - If a commit applies in the same cycle as start, start evaluates the pre-commit act_valid.
- FSM RUN: tpg_rst_n 1, registered, so it rises one cycle after entry. vs_rise -> frame_cnt+1, wraps modulo 2**FC_BITS. stop -> DRAIN, drain counter 0. start ignored.
- FSM DRAIN: tpg_rst_n 1, frame_cnt still counts.
  - vs_rise -> IDLE; a pending commit applies on that same edge.
  - Drain counter reaches DRAIN_MAX-1 -> IDLE, drain_tmo 1.
  - start/stop ignored.
- start and stop in the same cycle: stop wins (IDLE: nothing happens).
- Reset mid-operation: immediate return to reset values; tpg_rst_n drops asynchronously.
- cfg_err and drain_tmo clear only on reset or on an accepted start.

Decomposition:
- Shared package tpg_pkg: address constants (ADDR_HS_START..ADDR_V_END), NUM_TIMING_REGS=10, state encoding (IDLE, RUN, DRAIN).
- One natural sub-module: tpg_timing_check, the combinational validator. It takes the ten shadow values and produces ok.
- Top holds the banks, the FSM and the counters.

Test Plan:
- Write 640-mode values (HS 16/112, HACT 160/800, H_END 800; VS 10/12, VACT 45/525, V_END 525), commit in IDLE -> active bank equals shadow 1 cycle later, act_valid 1, cfg_err 0.
- Start with act_valid 0 -> stays IDLE, tpg_rst_n 0, cfg_err 1. Then valid commit + start -> RUN, tpg_rst_n 1 next cycle, cfg_err 0.
- In RUN, write HACT_END=700 and commit mid-frame -> tHACT_END still 800 until the vs_q rising edge, then 700. commit_pending is 1 throughout and clears on that edge.
- Commit HS_START=200, HS_END=100 -> active unchanged, cfg_err 1, commit_pending 0.
- Stop mid-frame -> busy stays 1 until the next vs_q rise, then IDLE and tpg_rst_n 0. frame_cnt equals the number of vs rises seen (e.g. 3).
- DRAIN_MAX=64 with vs_q held 0 after stop -> IDLE after 64 cycles, drain_tmo 1. start+stop same cycle in IDLE -> no state change.
